// File: rtl/adder_result_fmt.sv
`default_nettype none
// ============================================================================
//  Module      : adder_result_fmt
//  Description : Formats each adder result as an ASCII line
//                (PREFIX, carry digit, hex sum digit, CR? LF) and feeds it
//                byte by byte into a UART transmitter through a
//                start/ready handshake. A one-entry pending buffer holds a
//                result that arrives while a line is still being sent.
//  Revision    : 1.0 - initial release
// ============================================================================
module adder_result_fmt #(
    parameter logic [7:0] PREFIX   = 8'h3D,
    parameter bit         EOL_CRLF = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       result_valid,
    input  logic [3:0] result,
    input  logic       carry,
    input  logic       tx_ready,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       busy,
    output logic       overrun
);

    // Index of the final byte of a line (LF).
    localparam logic [2:0] c_LAST_IDX = EOL_CRLF ? 3'd4 : 3'd3;

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_SEND  = 3'd1;
    localparam logic [2:0] c_ST_WLOW  = 3'd2;
    localparam logic [2:0] c_ST_WHIGH = 3'd3;
    localparam logic [2:0] c_ST_DONE  = 3'd4;

    // Registered state
    logic [2:0] r_state;
    logic [2:0] r_idx;
    logic [4:0] r_line;        // {carry, result} of the line being sent
    logic [4:0] r_pend;        // {carry, result} waiting for the next line
    logic       r_pend_valid;
    logic       r_tx_start;
    logic [7:0] r_tx_data;
    logic       r_overrun;

    // Next-state values
    logic [2:0] w_state_nxt;
    logic [2:0] w_idx_nxt;
    logic [4:0] w_line_nxt;
    logic [4:0] w_pend_nxt;
    logic       w_pend_valid_nxt;
    logic       w_tx_start_nxt;
    logic [7:0] w_tx_data_nxt;
    logic       w_overrun_nxt;

    logic       w_pend_take;   // pending entry moves into the line register
    logic       w_to_pend;     // incoming result is parked in pending
    logic [7:0] w_hex;
    logic [7:0] w_byte;

    // Select the ASCII byte for the current index from the line register.
    always_comb begin
        w_hex = 8'h00;
        if (r_line[3:0] < 4'd10) begin
            w_hex = 8'h30 + {4'h0, r_line[3:0]};
        end else begin
            w_hex = 8'h37 + {4'h0, r_line[3:0]};
        end
        case (r_idx)
            3'd0:    w_byte = PREFIX;
            3'd1:    w_byte = {7'h18, r_line[4]};
            3'd2:    w_byte = w_hex;
            3'd3:    w_byte = EOL_CRLF ? 8'h0D : 8'h0A;
            default: w_byte = 8'h0A;
        endcase
    end

    // Pending buffer: any result not taken straight from IDLE is parked here;
    // a full buffer is overwritten by the newest result unless it is being
    // handed to the line register in the same cycle.
    always_comb begin
        w_pend_take      = ((r_state == c_ST_IDLE) || (r_state == c_ST_DONE)) && r_pend_valid;
        w_to_pend        = result_valid && ((r_state != c_ST_IDLE) || r_pend_valid);
        w_pend_nxt       = r_pend;
        w_pend_valid_nxt = r_pend_valid;
        w_overrun_nxt    = r_overrun;
        if (w_to_pend) begin
            w_pend_nxt       = {carry, result};
            w_pend_valid_nxt = 1'b1;
            if (r_pend_valid && !w_pend_take) begin
                w_overrun_nxt = 1'b1;
            end
        end else if (w_pend_take) begin
            w_pend_valid_nxt = 1'b0;
        end
    end

    // Line sequencer: next state, byte index, line register and tx outputs.
    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_line_nxt     = r_line;
        w_tx_start_nxt = 1'b0;
        w_tx_data_nxt  = r_tx_data;
        case (r_state)
            c_ST_IDLE: begin
                // A parked result is older than one arriving now, serve it first.
                if (r_pend_valid) begin
                    w_line_nxt  = r_pend;
                    w_idx_nxt   = 3'd0;
                    w_state_nxt = c_ST_SEND;
                end else if (result_valid) begin
                    w_line_nxt  = {carry, result};
                    w_idx_nxt   = 3'd0;
                    w_state_nxt = c_ST_SEND;
                end
            end
            c_ST_SEND: begin
                w_tx_data_nxt = w_byte;
                if (tx_ready) begin
                    w_tx_start_nxt = 1'b1;
                    w_state_nxt    = c_ST_WLOW;
                end
            end
            c_ST_WLOW: begin
                if (!tx_ready) begin
                    w_state_nxt = c_ST_WHIGH;
                end
            end
            c_ST_WHIGH: begin
                if (tx_ready) begin
                    if (r_idx == c_LAST_IDX) begin
                        w_state_nxt = c_ST_DONE;
                    end else begin
                        w_idx_nxt   = r_idx + 3'd1;
                        w_state_nxt = c_ST_SEND;
                    end
                end
            end
            c_ST_DONE: begin
                if (r_pend_valid) begin
                    w_line_nxt  = r_pend;
                    w_idx_nxt   = 3'd0;
                    w_state_nxt = c_ST_SEND;
                end else begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any line and pending result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_idx        <= 3'd0;
            r_line       <= 5'd0;
            r_pend       <= 5'd0;
            r_pend_valid <= 1'b0;
            r_tx_start   <= 1'b0;
            r_tx_data    <= 8'h00;
            r_overrun    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_line       <= w_line_nxt;
            r_pend       <= w_pend_nxt;
            r_pend_valid <= w_pend_valid_nxt;
            r_tx_start   <= w_tx_start_nxt;
            r_tx_data    <= w_tx_data_nxt;
            r_overrun    <= w_overrun_nxt;
        end
    end

    assign tx_start = r_tx_start;
    assign tx_data  = r_tx_data;
    assign overrun  = r_overrun;
    assign busy     = (r_state != c_ST_IDLE) || r_pend_valid;

endmodule
`default_nettype wire

// File: tb/tb_adder_result_fmt.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adder_result_fmt
//  Description : Scoreboard bench for adder_result_fmt. Two instances (CR LF
//                and LF-only line endings) share the result stimulus; each
//                has its own UART model that acknowledges bytes and compares
//                them against lines predicted from the result sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_result_fmt;

    logic       clk = 1'b0;
    logic       rst;
    logic       result_valid;
    logic [3:0] result;
    logic       carry;
    logic       hold;
    logic [1:0] rdy_eff;
    logic [1:0] tx_start;
    logic [7:0] tx_data [2];
    logic [1:0] busy;
    logic [1:0] overrun;

    always #5 clk = ~clk;

    adder_result_fmt #(.PREFIX(8'h3D), .EOL_CRLF(1'b1)) u_dut_crlf (
        .clk(clk), .rst(rst), .result_valid(result_valid), .result(result),
        .carry(carry), .tx_ready(rdy_eff[0]), .tx_start(tx_start[0]),
        .tx_data(tx_data[0]), .busy(busy[0]), .overrun(overrun[0])
    );

    adder_result_fmt #(.PREFIX(8'h3D), .EOL_CRLF(1'b0)) u_dut_lf (
        .clk(clk), .rst(rst), .result_valid(result_valid), .result(result),
        .carry(carry), .tx_ready(rdy_eff[1]), .tx_start(tx_start[1]),
        .tx_data(tx_data[1]), .busy(busy[1]), .overrun(overrun[1])
    );

    // Reference model: expected byte streams, bytes left in the current line,
    // one pending slot, and the expected sticky overrun flag per instance.
    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];
    int         rem      [2];
    bit         promoted [2];
    bit         pend_v   [2];
    logic [4:0] pend     [2];
    bit         exp_ovr  [2];
    int         starts   [2];
    int         raw_starts [2];
    int         n_tests = 0;
    int         n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic push_line(input int g, input logic [4:0] v);
        logic [7:0] b[$];
        b.push_back(8'h3D);
        b.push_back(8'h30 + 8'(v[4]));
        if (v[3:0] < 4'd10) b.push_back(8'h30 + 8'(v[3:0]));
        else                b.push_back(8'h41 + 8'(v[3:0]) - 8'd10);
        if (g == 0) b.push_back(8'h0D);
        b.push_back(8'h0A);
        foreach (b[i]) begin
            if (g == 0) exp_q0.push_back(b[i]);
            else        exp_q1.push_back(b[i]);
        end
        rem[g] = b.size();
    endtask

    task automatic model_clear();
        exp_q0.delete();
        exp_q1.delete();
        for (int g = 0; g < 2; g++) begin
            rem[g] = 0; promoted[g] = 0; pend_v[g] = 0; exp_ovr[g] = 0;
        end
    endtask

    // Called by a UART model whenever it accepts a byte.
    task automatic accept(input int g, input logic [7:0] d);
        logic [7:0] e;
        if ((g == 0 && exp_q0.size() == 0) || (g == 1 && exp_q1.size() == 0)) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_byte_inst%0d: got %02h, required no byte", g, d);
            return;
        end
        if (g == 0) e = exp_q0.pop_front();
        else        e = exp_q1.pop_front();
        check($sformatf("byte_inst%0d", g), 32'(d), 32'(e));
        if (rem[g] > 0) rem[g]--;
        if (rem[g] == 0 && pend_v[g]) begin
            push_line(g, pend[g]);
            pend_v[g]   = 0;
            promoted[g] = 1;
        end
    endtask

    // UART transmitter models: accept on start, stay busy a random time.
    for (genvar g = 0; g < 2; g++) begin : g_uart
        logic       rdy = 1'b1;
        int         cnt;
        logic       in_byte;
        logic [7:0] held;
        assign rdy_eff[g] = rdy & ~hold;
        initial begin
            in_byte = 1'b0;
            cnt     = 0;
            held    = 8'h00;
            forever begin
                @(negedge clk);
                if (rst) begin
                    rdy = 1'b1; in_byte = 1'b0; cnt = 0;
                end else begin
                    if (tx_start[g]) raw_starts[g]++;
                    if (tx_start[g] && !rdy_eff[g]) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL start_while_not_ready_inst%0d: got tx_start=1, required 0", g);
                    end else if (tx_start[g]) begin
                        starts[g]++;
                        accept(g, tx_data[g]);
                        rdy = 1'b0; in_byte = 1'b1; held = tx_data[g];
                        cnt = $urandom_range(0, 3);
                    end else if (in_byte) begin
                        check($sformatf("tx_data_stable_inst%0d", g), 32'(tx_data[g]), 32'(held));
                        if (cnt > 0) cnt--;
                        else begin rdy = 1'b1; in_byte = 1'b0; end
                    end
                end
            end
        end
    end

    // Fresh result while both instances are idle; caller sits at a negedge.
    task automatic issue_fresh(input logic [4:0] v);
        for (int g = 0; g < 2; g++) begin
            push_line(g, v);
            promoted[g] = 0;
        end
        result_valid = 1'b1; carry = v[4]; result = v[3:0];
        @(negedge clk);
        result_valid = 1'b0;
    endtask

    // Result during a line; only issued while the first line is safely mid-way.
    task automatic issue_mid(input logic [4:0] v, output bit ok);
        ok = !promoted[0] && !promoted[1] && rem[0] >= 2 && rem[1] >= 2;
        if (ok) begin
            for (int g = 0; g < 2; g++) begin
                if (pend_v[g]) exp_ovr[g] = 1;
                pend[g]   = v;
                pend_v[g] = 1;
            end
            result_valid = 1'b1; carry = v[4]; result = v[3:0];
            @(negedge clk);
            result_valid = 1'b0;
        end
    endtask

    task automatic wait_rem0(input int lim);
        int t = 0;
        while (rem[0] > lim && t < 500) begin @(negedge clk); t++; end
        check("wait_byte_timeout", 32'(t >= 500), 32'd0);
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0 || pend_v[0] || pend_v[1]) && t < 3000) begin
            @(negedge clk); t++;
        end
        check("drain_timeout", 32'(t >= 3000), 32'd0);
        repeat (12) @(negedge clk);
        check("busy_after_line", 32'(busy), 32'd0);
    endtask

    initial begin
        bit ok;
        int s0, s1;
        rst = 1'b1; result_valid = 1'b0; result = 4'h0; carry = 1'b0; hold = 1'b0;
        for (int g = 0; g < 2; g++) begin starts[g] = 0; raw_starts[g] = 0; end
        model_clear();
        repeat (3) @(negedge clk);
        check("reset_tx_start", 32'(tx_start), 32'd0);
        check("reset_tx_data0", 32'(tx_data[0]), 32'd0);
        check("reset_tx_data1", 32'(tx_data[1]), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_overrun", 32'(overrun), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single line: 7, carry 0; pulse count per line length.
        s0 = starts[0]; s1 = starts[1];
        issue_fresh(5'h07);
        drain();
        check("pulses_crlf", 32'(starts[0] - s0), 32'd5);
        check("pulses_lf", 32'(starts[1] - s1), 32'd4);

        // C with carry.
        s0 = starts[0]; s1 = starts[1];
        issue_fresh(5'h1C);
        drain();
        check("pulses_crlf_c", 32'(starts[0] - s0), 32'd5);
        check("pulses_lf_c", 32'(starts[1] - s1), 32'd4);

        // Second result mid-line is queued, no overrun.
        issue_fresh(5'h05);
        wait_rem0(4);
        issue_mid(5'h02, ok);
        check("mid_issue_window", 32'(ok), 32'd1);
        drain();
        check("overrun_after_one_pending", 32'(overrun), 32'd0);

        // Three results in one line: only the newest survives, overrun set.
        issue_fresh(5'h00);
        issue_mid(5'h01, ok); check("mid1_window", 32'(ok), 32'd1);
        issue_mid(5'h05, ok); check("mid5_window", 32'(ok), 32'd1);
        issue_mid(5'h09, ok); check("mid9_window", 32'(ok), 32'd1);
        drain();
        check("overrun_sticky", 32'(overrun), {30'd0, exp_ovr[1], exp_ovr[0]});
        check("overrun_set", 32'(overrun), 32'd3);

        // Ready held low: no start pulses until it returns.
        hold = 1'b1;
        s0 = raw_starts[0]; s1 = raw_starts[1];
        issue_fresh(5'h13);
        repeat (200) @(negedge clk);
        check("no_start_while_held", 32'((raw_starts[0] - s0) + (raw_starts[1] - s1)), 32'd0);
        check("busy_while_held", 32'(busy), 32'd3);
        hold = 1'b0;
        drain();

        // Asynchronous reset in the middle of a line.
        issue_fresh(5'h0A);
        wait_rem0(2);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tx_data0", 32'(tx_data[0]), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        model_clear();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        s0 = raw_starts[0];
        repeat (10) @(negedge clk);
        check("no_start_after_rst", 32'(raw_starts[0] - s0), 32'd0);
        issue_fresh(5'h0F);
        drain();

        // Randomized lines with 0..3 results arriving mid-line.
        for (int it = 0; it < 25; it++) begin
            int n_extra;
            issue_fresh(5'($urandom_range(0, 31)));
            n_extra = $urandom_range(0, 3);
            for (int k = 0; k < n_extra; k++) begin
                repeat ($urandom_range(0, 6)) @(negedge clk);
                issue_mid(5'($urandom_range(0, 31)), ok);
            end
            drain();
            check("overrun_random", 32'(overrun), {30'd0, exp_ovr[1], exp_ovr[0]});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
